// File: rtl/ky32_store_buffer.sv
// ky32_store_buffer: posted-write buffer between the kythera32 store path
// and data memory. Stores enter a circular FIFO in one cycle. They drain to
// memory in order, one per cycle. Loads are compared against every queued
// entry so that a load never returns stale data.
//
// Handshakes:
//   store side  - a store is accepted on a rising edge where st_valid && st_ready.
//                 st_ready is !full and depends only on registered state.
//   memory side - a write completes on a rising edge where mem_we && mem_ready.
//                 mem_addr and mem_wdata are held while mem_we && !mem_ready.
//
// Optional feature macro: KY32_SB_FWD_EN
//   defined   - a matching load is forwarded from the youngest matching entry
//               (ld_hit/ld_data), and ld_conflict stays 0.
//   undefined - no forward mux. ld_conflict flags any match, ld_hit and
//               ld_data stay 0.
module ky32_store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     st_valid,
    input  logic [AW-1:0]            st_addr,
    input  logic [DW-1:0]            st_data,
    output logic                     st_ready,
    input  logic [AW-1:0]            ld_addr,
    output logic                     ld_hit,
    output logic [DW-1:0]            ld_data,
    output logic                     ld_conflict,
    output logic                     mem_we,
    output logic [AW-1:0]            mem_addr,
    output logic [DW-1:0]            mem_wdata,
    input  logic                     mem_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0]    addr_q  [DEPTH];
    logic [DW-1:0]    data_q  [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic [DEPTH-1:0] match_vec;

    // Occupancy flags and the two handshakes, all from registered state.
    always_comb begin
        full     = (count_q == CW'(DEPTH));
        empty    = (count_q == '0);
        st_ready = !full;
        mem_we   = !empty;
        push     = st_valid && !full;
        pop      = !empty && mem_ready;
    end

    // The memory side reads the oldest entry directly.
    assign mem_addr  = addr_q[rd_ptr];
    assign mem_wdata = data_q[rd_ptr];
    assign count     = count_q;

    // FIFO storage, pointers and occupancy. Reset discards all queued stores.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
            valid_q <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                addr_q[wr_ptr]  <= st_addr;
                data_q[wr_ptr]  <= st_data;
                valid_q[wr_ptr] <= 1'b1;
                wr_ptr          <= wr_ptr + PW'(1);
            end
            // A push and a pop never target the same slot: a push needs
            // !full and a pop needs !empty.
            if (pop) begin
                valid_q[rd_ptr] <= 1'b0;
                rd_ptr          <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Full-width address compare of the load against every valid entry.
    // Only registered contents are seen, so the entry leaving this cycle
    // still matches and the store arriving this cycle does not.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            match_vec[i] = valid_q[i] && (addr_q[i] == ld_addr);
        end
    end

`ifdef KY32_SB_FWD_EN
    // Scan from oldest to youngest. The last match found is the youngest
    // store to that address, which is the data the load must see.
    always_comb begin
        logic [PW-1:0] scan_idx;
        ld_hit      = 1'b0;
        ld_data     = '0;
        ld_conflict = 1'b0;
        scan_idx    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = rd_ptr + PW'(i);
            if (match_vec[scan_idx]) begin
                ld_hit  = 1'b1;
                ld_data = data_q[scan_idx];
            end
        end
    end
`else
    // Without forwarding, any match stalls the load until the store drains.
    always_comb begin
        ld_hit      = 1'b0;
        ld_data     = '0;
        ld_conflict = |match_vec;
    end
`endif

endmodule

// File: tb/tb_ky32_store_buffer.sv
// Directed bench for ky32_store_buffer. Inputs change #1 after a rising edge
// and outputs are sampled #1 later, away from the active edge.
module tb_ky32_store_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;

    logic          clk;
    logic          rst;
    logic          st_valid;
    logic [AW-1:0] st_addr;
    logic [DW-1:0] st_data;
    logic          st_ready;
    logic [AW-1:0] ld_addr;
    logic          ld_hit;
    logic [DW-1:0] ld_data;
    logic          ld_conflict;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ready;
    logic [2:0]    count;

    int n_checks;
    int n_fail;

    ky32_store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .st_valid   (st_valid),
        .st_addr    (st_addr),
        .st_data    (st_data),
        .st_ready   (st_ready),
        .ld_addr    (ld_addr),
        .ld_hit     (ld_hit),
        .ld_data    (ld_data),
        .ld_conflict(ld_conflict),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .count      (count)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and land #1 after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a single store for one cycle.
    task automatic push_one(input logic [AW-1:0] a, input logic [DW-1:0] d);
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        step();
        st_valid = 1'b0;
    endtask

    logic [AW-1:0] a_tab [5];
    logic [AW-1:0] prev_a;

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        st_valid  = 1'b0;
        st_addr   = '0;
        st_data   = '0;
        ld_addr   = '0;
        mem_ready = 1'b0;
        a_tab[0] = 32'h10; a_tab[1] = 32'h14; a_tab[2] = 32'h18;
        a_tab[3] = 32'h1C; a_tab[4] = 32'h20;

        // Reset then idle
        step();
        step();
        rst = 1'b0;
        step();
        #1;
        check_eq("rst_count",    count,       0);
        check_eq("rst_st_ready", st_ready,    1);
        check_eq("rst_mem_we",   mem_we,      0);
        check_eq("rst_mem_addr", mem_addr,    0);
        check_eq("rst_mem_wd",   mem_wdata,   0);
        check_eq("rst_ld_hit",   ld_hit,      0);
        check_eq("rst_ld_data",  ld_data,     0);
        check_eq("rst_ld_conf",  ld_conflict, 0);

        // Fill to full with memory stalled; the fifth store is ignored.
        for (int i = 0; i < 5; i++) begin
            push_one(a_tab[i], 32'hD000_0000 + a_tab[i]);
            #1;
            check_eq("fill_count", count, (i < 4) ? i + 1 : 4);
            check_eq("fill_mem_addr", mem_addr, 32'h10);
            check_eq("fill_mem_wd", mem_wdata, 32'hD000_0010);
        end
        check_eq("full_st_ready", st_ready, 0);
        check_eq("full_mem_we", mem_we, 1);

        // The ignored store's address must not be queued.
        ld_addr = 32'h20;
        #1;
`ifdef KY32_SB_FWD_EN
        check_eq("full_ld_hit_20", ld_hit, 0);
`else
        check_eq("full_ld_conf_20", ld_conflict, 0);
`endif

        // Drain in order.
        ld_addr   = 32'h0;
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_eq("drain_mem_we", mem_we, 1);
            check_eq("drain_mem_addr", mem_addr, a_tab[i]);
            check_eq("drain_mem_wd", mem_wdata, 32'hD000_0000 + a_tab[i]);
            step();
        end
        #1;
        check_eq("drained_mem_we", mem_we, 0);
        check_eq("drained_count", count, 0);
        check_eq("drained_st_ready", st_ready, 1);

        // Simultaneous push and pop, ten stores wrapping the pointers.
        prev_a = '0;
        for (int i = 0; i < 10; i++) begin
            st_valid = 1'b1;
            st_addr  = 32'h100 + 4 * i;
            st_data  = 32'h5500_0000 + i;
            #1;
            if (i > 0) begin
                check_eq("wrap_mem_addr", mem_addr, prev_a);
                check_eq("wrap_mem_wd", mem_wdata, 32'h5500_0000 + i - 1);
            end
            prev_a = 32'h100 + 4 * i;
            step();
            #1;
            check_eq("wrap_count", count, 1);
        end
        st_valid = 1'b0;
        #1;
        check_eq("wrap_last_addr", mem_addr, 32'h124);
        step();
        #1;
        check_eq("wrap_end_count", count, 0);

        // Forwarding / conflict with two stores to the same address.
        mem_ready = 1'b0;
        push_one(32'h40, 32'hAAAA0001);
        push_one(32'h40, 32'hBBBB0002);
        ld_addr = 32'h40;
        #1;
`ifdef KY32_SB_FWD_EN
        check_eq("fwd_hit", ld_hit, 1);
        check_eq("fwd_data", ld_data, 32'hBBBB0002);
        check_eq("fwd_conf", ld_conflict, 0);
`else
        check_eq("conf_conf", ld_conflict, 1);
        check_eq("conf_hit", ld_hit, 0);
        check_eq("conf_data", ld_data, 0);
`endif
        ld_addr = 32'h44;
        #1;
`ifdef KY32_SB_FWD_EN
        check_eq("fwd_miss_hit", ld_hit, 0);
`else
        check_eq("conf_miss_conf", ld_conflict, 0);
`endif

        // Drain both; the match persists until the last one leaves.
        ld_addr   = 32'h40;
        mem_ready = 1'b1;
        #1;
        check_eq("same_addr_wd0", mem_wdata, 32'hAAAA0001);
        step();
        #1;
        check_eq("same_addr_wd1", mem_wdata, 32'hBBBB0002);
`ifdef KY32_SB_FWD_EN
        check_eq("fwd_mid_data", ld_data, 32'hBBBB0002);
`else
        check_eq("conf_mid_conf", ld_conflict, 1);
`endif
        step();
        #1;
`ifdef KY32_SB_FWD_EN
        check_eq("fwd_end_hit", ld_hit, 0);
`else
        check_eq("conf_end_conf", ld_conflict, 0);
`endif
        check_eq("fwd_end_count", count, 0);

        // Reset overrides a push and a pop in the same cycle.
        mem_ready = 1'b0;
        push_one(32'h80, 32'h1);
        push_one(32'h84, 32'h2);
        rst       = 1'b1;
        mem_ready = 1'b1;
        st_valid  = 1'b1;
        st_addr   = 32'h88;
        st_data   = 32'h3;
        step();
        rst      = 1'b0;
        st_valid = 1'b0;
        #1;
        check_eq("mid_rst_count", count, 0);
        check_eq("mid_rst_mem_we", mem_we, 0);
        check_eq("mid_rst_mem_addr", mem_addr, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
